// File: rtl/cmdin_dispatcher_pkg.sv
// Shared constants, header field layout, command length rule and FSM states
// for the cmdin queue dispatcher.
package cmdin_dispatcher_pkg;

  localparam logic [7:0] EXEC_TASK_CODE      = 8'h01;
  localparam logic [7:0] SETUP_HW_INST_CODE  = 8'h02;
  localparam logic [7:0] EXEC_PERI_TASK_CODE = 8'h05;

  localparam int ENTRY_VALID_BYTE_OFFSET = 56;
  localparam int CMD_TYPE_L              = 0;
  localparam int CMD_TYPE_H              = 7;
  localparam int NUM_ARGS_OFFSET         = 8;

  localparam logic [7:0] ENTRY_VALID = 8'h80;

  typedef enum logic [2:0] {
    S_SCAN,
    S_HDR_WAIT,
    S_HDR_CHECK,
    S_SEND,
    S_RD_WAIT,
    S_CLEAR
  } state_e;

  function automatic logic cmd_known(input logic [7:0] code);
    return code inside {EXEC_TASK_CODE, SETUP_HW_INST_CODE, EXEC_PERI_TASK_CODE};
  endfunction

  // Length in 64-bit slots; 9-bit arithmetic wraps like the hardware it models.
  function automatic logic [8:0] cmd_length(input logic [7:0] code, input logic [7:0] n_args);
    logic [8:0] two_n;
    two_n = {n_args, 1'b0};
    case (code)
      EXEC_TASK_CODE:      return 9'd3 + two_n;
      SETUP_HW_INST_CODE:  return 9'd2;
      EXEC_PERI_TASK_CODE: return 9'd4 + two_n;
      default:             return 9'd1;
    endcase
  endfunction

endpackage

// File: rtl/cmdin_dispatcher_if.sv
// Memory port and command stream between the dispatcher (master) and the
// cmdin BRAM / accelerator interconnect (slave).
interface cmdin_dispatcher_if;
  logic        mem_en;
  logic [7:0]  mem_wr;
  logic [31:0] mem_addr;
  logic [63:0] mem_din;
  logic [63:0] mem_dout;

  // Stream: a beat transfers on a cycle with cmd_tvalid && cmd_tready; once
  // cmd_tvalid rises, tdata/tdest/tlast hold until that transfer happens.
  logic [63:0] cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [7:0]  cmd_tdest;
  logic        cmd_tlast;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_din,
    input  mem_dout,
    output cmd_tdata, cmd_tvalid, cmd_tdest, cmd_tlast,
    input  cmd_tready
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_din,
    output mem_dout,
    input  cmd_tdata, cmd_tvalid, cmd_tdest, cmd_tlast,
    output cmd_tready
  );
endinterface

// File: rtl/cmdin_rr_pointer.sv
// Round-robin successor of the current accelerator index, modulo NUM_ACCS.
module cmdin_rr_pointer #(
  parameter int NUM_ACCS = 16,
  parameter int ACC_W    = 4
) (
  input  logic [ACC_W-1:0] rr_i,
  output logic [ACC_W-1:0] rr_nxt_o
);
  assign rr_nxt_o = (rr_i == ACC_W'(NUM_ACCS - 1)) ? '0 : rr_i + ACC_W'(1);
endmodule

// File: rtl/cmdin_dispatcher.sv
// Round-robin consumer of the per-accelerator cmdin queues; streams each valid
// command, then frees its header. CMDIN_DISPATCH_STATS_EN adds per-acc counters.
module cmdin_dispatcher
  import cmdin_dispatcher_pkg::*;
#(
  parameter int NUM_ACCS       = 16,
  parameter int QUEUE_LEN_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  cmdin_dispatcher_if.master  bus,
  input  logic [NUM_ACCS-1:0] acc_avail,
  output logic                dispatch,
  output logic [7:0]          dispatch_acc,
  output logic                bad_cmd,
  output state_e              dbg_state_o
`ifdef CMDIN_DISPATCH_STATS_EN
  ,
  input  logic [7:0]          stat_acc,
  output logic [31:0]         stat_count
`endif
);

  localparam int ACC_W = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1;
  localparam int QL    = QUEUE_LEN_LOG2;
  typedef logic [QL-1:0] slot_t;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] rr_q, rr_d, rr_nxt;
  slot_t            rd_idx_q [NUM_ACCS];
  slot_t            rd_idx_cur, rd_idx_upd, mem_slot;
  logic             rd_idx_we;
  logic [63:0]      word_q, word_d;
  logic [8:0]       len_q, len_d, w_q, w_d;
  logic [7:0]       hdr_valid, hdr_code, hdr_nargs, rr_id;
  logic             last_beat;

  cmdin_rr_pointer #(.NUM_ACCS(NUM_ACCS), .ACC_W(ACC_W)) u_rr (
    .rr_i     (rr_q),
    .rr_nxt_o (rr_nxt)
  );

  assign rr_id       = 8'(rr_q);
  assign rd_idx_cur  = rd_idx_q[rr_q];
  assign hdr_valid   = bus.mem_dout[ENTRY_VALID_BYTE_OFFSET +: 8];
  assign hdr_code    = bus.mem_dout[CMD_TYPE_H:CMD_TYPE_L];
  assign hdr_nargs   = bus.mem_dout[NUM_ARGS_OFFSET +: 8];
  assign last_beat   = (w_q == len_q - 9'd1);
  assign dbg_state_o = state_q;

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    word_d         = word_q;
    len_d          = len_q;
    w_d            = w_q;
    rd_idx_we      = 1'b0;
    rd_idx_upd     = rd_idx_cur;
    mem_slot       = rd_idx_cur;
    bus.mem_en     = 1'b0;
    bus.mem_wr     = 8'h00;
    bus.mem_addr   = '0;
    bus.mem_din    = '0;
    bus.cmd_tvalid = 1'b0;
    bus.cmd_tdata  = '0;
    bus.cmd_tdest  = '0;
    bus.cmd_tlast  = 1'b0;
    dispatch       = 1'b0;
    dispatch_acc   = '0;
    bad_cmd        = 1'b0;

    // Outputs stay quiet while reset is held, whatever state is still registered.
    if (!rst) begin
      case (state_q)
        S_SCAN: begin
          if (acc_avail[rr_q]) begin
            bus.mem_en = 1'b1;
            state_d    = S_HDR_WAIT;
          end else begin
            rr_d = rr_nxt;
          end
        end
        S_HDR_WAIT: state_d = S_HDR_CHECK;
        S_HDR_CHECK: begin
          if (hdr_valid != ENTRY_VALID) begin
            rr_d    = rr_nxt;
            state_d = S_SCAN;
          end else if (!cmd_known(hdr_code)) begin
            bad_cmd = 1'b1;
            len_d   = 9'd1;
            state_d = S_CLEAR;
          end else begin
            word_d  = bus.mem_dout;
            len_d   = cmd_length(hdr_code, hdr_nargs);
            w_d     = '0;
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          bus.cmd_tvalid = 1'b1;
          bus.cmd_tdata  = word_q;
          bus.cmd_tdest  = rr_id;
          bus.cmd_tlast  = last_beat;
          if (bus.cmd_tready) begin
            if (last_beat) begin
              state_d = S_CLEAR;
            end else begin
              bus.mem_en = 1'b1;
              mem_slot   = rd_idx_cur + slot_t'(w_q) + slot_t'(1);
              state_d    = S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          word_d  = bus.mem_dout;
          w_d     = w_q + 9'd1;
          state_d = S_SEND;
        end
        S_CLEAR: begin
          // Byte 7 only: zeroes the valid byte, leaves the rest of the header.
          bus.mem_en   = 1'b1;
          bus.mem_wr   = 8'h80;
          rd_idx_we    = 1'b1;
          rd_idx_upd   = rd_idx_cur + slot_t'(len_q);
          dispatch     = 1'b1;
          dispatch_acc = rr_id;
          rr_d         = rr_nxt;
          state_d      = S_SCAN;
        end
        default: state_d = S_SCAN;
      endcase
      if (bus.mem_en)
        bus.mem_addr = 32'({rr_id, mem_slot, 3'b000});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SCAN;
      rr_q    <= '0;
      word_q  <= '0;
      len_q   <= '0;
      w_q     <= '0;
      for (int a = 0; a < NUM_ACCS; a++) rd_idx_q[a] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      word_q  <= word_d;
      len_q   <= len_d;
      w_q     <= w_d;
      if (rd_idx_we) rd_idx_q[rr_q] <= rd_idx_upd;
    end
  end

`ifdef CMDIN_DISPATCH_STATS_EN
  logic [31:0] stat_cnt_q [NUM_ACCS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NUM_ACCS; a++) stat_cnt_q[a] <= '0;
    end else if (dispatch) begin
      stat_cnt_q[rr_q] <= stat_cnt_q[rr_q] + 32'd1;
    end
  end

  assign stat_count = ({1'b0, stat_acc} < 9'(NUM_ACCS)) ? stat_cnt_q[stat_acc[ACC_W-1:0]] : '0;
`endif

endmodule
